// File: rtl/core_result_collector.sv
// core_result_collector: latches each core's result on the falling edge of its
// result-ready strobe, then sums the results once all enabled cores finish or time runs out.
module core_result_collector #(
    parameter int CORES       = 4,
    parameter int DATA_W      = 8,
    parameter int SUM_W       = 11,
    parameter int CYC_W       = 16,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [31:0]         out_strobe,
    input  logic [8*DATA_W-1:0] result,
    output logic [7:0]          core_done,
    output logic [8*DATA_W-1:0] core_result,
    output logic [CYC_W-1:0]    cycles,
    output logic [SUM_W-1:0]    total,
    output logic                total_valid,
    output logic                timed_out
);
    localparam logic [7:0]       LANE_MASK    = 8'((9'd1 << CORES) - 9'd1);
    localparam logic [2:0]       LAST_LANE    = 3'(CORES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {COLLECT, ACCUM, DONE} state_t;
    state_t state, state_next;

    logic [7:0]             rdy, rdy_q, latch;
    logic [7:0][DATA_W-1:0] res_in, res_q;
    logic [2:0]             k;
    logic [SUM_W-1:0]       acc, acc_next;
    logic                   all_done, at_timeout, last_lane;
    logic                   unused_strobe;

    for (genvar g = 0; g < 8; g++) begin : g_lane
        assign rdy[g] = out_strobe[4*g+2];
    end

    assign unused_strobe = ^out_strobe;
    assign res_in        = result;
    assign core_result   = res_q;

    // Latching stays live through ACCUM but stops in DONE so the final picture is frozen.
    assign latch      = rdy_q & ~rdy & LANE_MASK & ~core_done & {8{state != DONE}};
    assign all_done   = (core_done & LANE_MASK) == LANE_MASK;
    assign at_timeout = cycles == TIMEOUT_LAST;
    assign last_lane  = k == LAST_LANE;
    assign acc_next   = acc + (core_done[k] ? SUM_W'(res_q[k]) : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= COLLECT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (all_done || at_timeout) state_next = ACCUM;
            ACCUM:   if (last_lane) state_next = DONE;
            default: state_next = state;
        endcase
        if (clear) state_next = COLLECT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q       <= '0;
            core_done   <= '0;
            res_q       <= '0;
            cycles      <= '0;
            total       <= '0;
            total_valid <= 1'b0;
            timed_out   <= 1'b0;
            acc         <= '0;
            k           <= '0;
        end else if (clear) begin
            rdy_q       <= '0;
            core_done   <= '0;
            res_q       <= '0;
            cycles      <= '0;
            total       <= '0;
            total_valid <= 1'b0;
            timed_out   <= 1'b0;
            acc         <= '0;
            k           <= '0;
        end else begin
            rdy_q <= rdy;
            for (int i = 0; i < 8; i++) begin
                if (latch[i]) begin
                    core_done[i] <= 1'b1;
                    res_q[i]     <= res_in[i];
                end
            end
            case (state)
                COLLECT: begin
                    // The exit cycle still counts, so a timeout leaves cycles == TIMEOUT_CYC.
                    cycles <= cycles + CYC_W'(1);
                    acc    <= '0;
                    k      <= '0;
                    if (!all_done && at_timeout) timed_out <= 1'b1;
                end
                ACCUM: begin
                    acc <= acc_next;
                    k   <= k + 3'd1;
                    if (last_lane) begin
                        total       <= acc_next;
                        total_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
